// File: rtl/mph_ascii_tx.sv
// mph_ascii_tx
//   Turns a binary speed in mph x100 into the ASCII frame "III.FF<CR><LF>"
//   and hands it to the UART transmitter one byte at a time over a
//   valid/ready handshake. The conversion runs binary -> BCD with a
//   sequential double-dabble, then each BCD digit is sent as an ASCII byte.
//
// Parameters
//   APPEND_CRLF    1: frame ends with CR,LF (8 bytes); 0: 6-byte frame
//   BLANK_LEADING  1: leading integer zeros become spaces (units never blanked)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     begin a frame; sampled only while busy=0
//   mph_x100  speed in mph x100, unsigned (0.00 .. 655.35)
//   tx_data   ASCII byte to the UART
//   tx_valid  tx_data is valid
//   tx_ready  UART takes the byte when tx_valid & tx_ready at a rising edge
//   busy      frame in progress (converting or sending)
//   done      one-cycle pulse after the last byte of a frame is accepted
module mph_ascii_tx #(
  parameter bit APPEND_CRLF   = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mph_x100,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

  localparam logic [2:0] LAST_IDX = APPEND_CRLF ? 3'd7 : 3'd5;

  state_t      state;
  state_t      next_state;
  logic [15:0] shift_reg;
  logic [19:0] bcd;
  logic [19:0] bcd_adj;
  logic [4:0]  bit_cnt;
  logic [2:0]  char_idx;
  logic [7:0]  first_char;
  logic [7:0]  next_char;
  logic        xfer;
  logic        last_xfer;

  // Byte at position idx of the frame, built from the five BCD digits.
  function automatic logic [7:0] frame_char(input logic [19:0] b, input logic [2:0] idx);
    logic [3:0] d4, d3, d2, d1, d0;
    logic [7:0] c;
    d4 = b[19:16];
    d3 = b[15:12];
    d2 = b[11:8];
    d1 = b[7:4];
    d0 = b[3:0];
    case (idx)
      3'd0:    c = (BLANK_LEADING && d4 == 4'd0) ? 8'h20 : {4'h3, d4};
      3'd1:    c = (BLANK_LEADING && d4 == 4'd0 && d3 == 4'd0) ? 8'h20 : {4'h3, d3};
      3'd2:    c = {4'h3, d2};
      3'd3:    c = 8'h2E;
      3'd4:    c = {4'h3, d1};
      3'd5:    c = {4'h3, d0};
      3'd6:    c = 8'h0D;
      default: c = 8'h0A;
    endcase
    return c;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic. CONV spends 16 shift cycles plus one load cycle
  // (bit_cnt == 16) where the first character is presented.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CONV;
      CONV:    if (bit_cnt == 5'd16) next_state = SEND;
      SEND:    if (last_xfer) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output/datapath decode: add-3 correction for double-dabble, handshake
  // qualifiers, and the characters to load on the next edge.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    xfer       = tx_valid & tx_ready;
    last_xfer  = xfer && (char_idx == LAST_IDX);
    first_char = frame_char(bcd, 3'd0);
    next_char  = frame_char(bcd, char_idx + 3'd1);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      char_idx  <= '0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= mph_x100;
            bcd       <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b1;
          end
        end
        CONV: begin
          if (bit_cnt == 5'd16) begin
            char_idx <= 3'd0;
            tx_data  <= first_char;
            tx_valid <= 1'b1;
          end else begin
            // Top bit of the adjusted BCD is always zero for 16-bit input.
            bcd       <= {bcd_adj[18:0], shift_reg[15]};
            shift_reg <= {shift_reg[14:0], 1'b0};
            bit_cnt   <= bit_cnt + 5'd1;
          end
        end
        SEND: begin
          if (xfer) begin
            if (char_idx == LAST_IDX) begin
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              char_idx <= char_idx + 3'd1;
              tx_data  <= next_char;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mph_ascii_tx.sv
// tb_mph_ascii_tx
//   Directed bench for mph_ascii_tx. A default instance (blanking on, CRLF on)
//   and a second instance (blanking off, 6-byte frame) share the same inputs;
//   accepted bytes from each are collected into queues and compared with
//   hand-computed frames.
module tb_mph_ascii_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] mph_x100;
  logic        tx_ready;
  logic [7:0]  tx_data, tx_data_nb;
  logic        tx_valid, tx_valid_nb;
  logic        busy, busy_nb;
  logic        done, done_nb;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  mph_ascii_tx u_dut (
    .clk(clk), .rst(rst), .start(start), .mph_x100(mph_x100),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  mph_ascii_tx #(.APPEND_CRLF(1'b0), .BLANK_LEADING(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .start(start), .mph_x100(mph_x100),
    .tx_data(tx_data_nb), .tx_valid(tx_valid_nb), .tx_ready(tx_ready),
    .busy(busy_nb), .done(done_nb)
  );

  always #5 clk = ~clk;

  // Edge counter, byte collectors and done-pulse counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && tx_valid && tx_ready) q1.push_back(tx_data);
    if (!rst && tx_valid_nb && tx_ready) q2.push_back(tx_data_nb);
    if (done) done_cnt <= done_cnt + 1;
  end

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; n returns the edge number that sampled it.
  task applyStimulus(input logic [15:0] val, output int n);
    @(negedge clk);
    mph_x100 = val;
    start = 1'b1;
    q1.delete();
    q2.delete();
    @(negedge clk);
    start = 1'b0;
    n = cyc;
  endtask

  task waitDone(output int at);
    at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) checkOutput("done_timeout", 0, 1);
  endtask

  task waitValid(output int at);
    at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) checkOutput("valid_timeout", 0, 1);
  endtask

  // Wait until n bytes were accepted and the next one is being presented.
  task waitBytes(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q1.size() == n && tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("bytes_timeout", 0, 1);
  endtask

  task checkFrame(input string tag, input bit nb, input logic [63:0] exp, input int n);
    int sz;
    logic [7:0] got;
    sz = nb ? q2.size() : q1.size();
    checkOutput({tag, "_len"}, sz, n);
    for (int i = 0; i < n; i++) begin
      if (i < sz) got = nb ? q2[i] : q1[i];
      else        got = 8'hxx;
      checkOutput($sformatf("%s_b%0d", tag, i), {24'h0, got}, {24'h0, exp[63-8*i -: 8]});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, n2, v, d, d2, cnt0;
    rst = 1'b1;
    start = 1'b0;
    mph_x100 = 16'd0;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_tx_data", {24'h0, tx_data}, 32'h0);
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    rst = 1'b0;

    $display("[TB] T1 latency and basic frame");
    applyStimulus(16'd1234, n);
    checkOutput("t1_busy", busy, 1);
    waitValid(v);
    checkOutput("t1_valid_lat", v, n + 17);
    waitDone(d);
    checkOutput("t1_done_lat", d, n + 25);
    checkFrame("t1", 1'b0, 64'h2031322E33340D0A, 8);
    @(negedge clk);
    checkOutput("t1_done_width", done, 0);
    checkOutput("t1_busy_end", busy, 0);

    $display("[TB] T2/T3 value patterns");
    applyStimulus(16'd0, n);
    waitDone(d);
    checkFrame("t2", 1'b0, 64'h2020302E30300D0A, 8);
    checkFrame("t2nb", 1'b1, {48'h3030302E3030, 16'h0}, 6);
    applyStimulus(16'd65535, n);
    waitDone(d);
    checkFrame("t3max", 1'b0, 64'h3635352E33350D0A, 8);
    checkFrame("t3maxnb", 1'b1, {48'h3635352E3335, 16'h0}, 6);
    applyStimulus(16'd1005, n);
    waitDone(d);
    checkFrame("t3", 1'b0, 64'h2031302E30350D0A, 8);
    checkFrame("t3nb", 1'b1, {48'h3031302E3035, 16'h0}, 6);

    $display("[TB] T4 backpressure");
    applyStimulus(16'd4321, n);
    waitBytes(2);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t4_hold_data%0d", i), {24'h0, tx_data}, 32'h33);
      checkOutput($sformatf("t4_hold_valid%0d", i), tx_valid, 1);
      @(negedge clk);
    end
    tx_ready = 1'b1;
    waitDone(d);
    checkFrame("t4", 1'b0, 64'h2034332E32310D0A, 8);

    $display("[TB] T5 start ignored while busy, then back-to-back");
    applyStimulus(16'd1234, n);
    waitBytes(2);
    mph_x100 = 16'd9999;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(d);
    cnt0 = done_cnt;
    checkFrame("t5", 1'b0, 64'h2031322E33340D0A, 8);
    repeat (30) @(negedge clk);
    checkOutput("t5_no_queue_busy", busy, 0);
    checkOutput("t5_no_queue_done", done_cnt, cnt0 + 1);
    checkOutput("t5_no_queue_bytes", q1.size(), 8);

    applyStimulus(16'd1234, n);
    waitDone(d);
    checkFrame("t5_first", 1'b0, 64'h2031322E33340D0A, 8);
    mph_x100 = 16'd5;
    start = 1'b1;
    q1.delete();
    @(negedge clk);
    start = 1'b0;
    n2 = cyc;
    checkOutput("t5_b2b_busy", busy, 1);
    waitDone(d2);
    checkOutput("t5_b2b_done_lat", d2, n2 + 25);
    checkFrame("t5_b2b", 1'b0, 64'h2020302E30350D0A, 8);

    $display("[TB] T6 reset mid-frame");
    applyStimulus(16'd1234, n);
    waitBytes(4);
    cnt0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_valid", tx_valid, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_done", done, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("t6_no_done", done_cnt, cnt0);
    checkOutput("t6_partial", q1.size(), 4);
    applyStimulus(16'd1234, n);
    waitDone(d);
    checkFrame("t6_after", 1'b0, 64'h2031322E33340D0A, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
